// File: rtl/mem_responder.sv
// Single-outstanding memory responder: latches one request, waits LATENCY cycles, performs the
// access against physical memory and holds the response until the requester takes it.

// Behavioural stand-in for the pmem_read / pmem_write DPI-C functions; global state like the C side.
package pmem_pkg;
    logic [31:0] mem [logic [31:0]];
    int unsigned n_reads;
    int unsigned n_writes;

    function automatic logic [31:0] pmem_read(input logic [31:0] addr);
        n_reads++;
        if (mem.exists(addr)) return mem[addr];
        return '0;
    endfunction

    function automatic void pmem_write(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [7:0] mask);
        logic [31:0] w;
        w = mem.exists(addr) ? mem[addr] : '0;
        n_writes++;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) w[8*i +: 8] = data[8*i +: 8];
        end
        mem[addr] = w;
    endfunction

    function automatic void pmem_preload(input logic [31:0] addr, input logic [31:0] data);
        mem[addr] = data;
    endfunction

    function automatic logic [31:0] pmem_peek(input logic [31:0] addr);
        if (mem.exists(addr)) return mem[addr];
        return '0;
    endfunction
endpackage

module mem_responder #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LATENCY  = 1,
    parameter logic [31:0] MEM_BASE = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE = 32'h0800_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    import pmem_pkg::*;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);
    // 33-bit bounds so MEM_BASE + MEM_SIZE cannot wrap
    localparam logic [32:0] RangeLo = {1'b0, MEM_BASE};
    localparam logic [32:0] RangeHi = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              do_access;
    logic              in_range;
    logic [ADDR_W:0]   addr_ext;
    logic [31:0]       word_addr;

    assign addr_ext  = {1'b0, addr_q};
    assign in_range  = (addr_ext >= RangeLo) && (addr_ext < RangeHi);
    assign word_addr = {addr_q[31:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    cnt_d   = CntInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    do_access = 1'b1;
                    err_d     = ~in_range;
                    rdata_d   = '0;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            err_q   <= err_d;
            if (do_access && in_range && !wen_q) begin
                rdata_q <= pmem_read(word_addr);
            end else begin
                rdata_q <= rdata_d;
            end
            // Zero-mask writes complete normally without touching memory
            if (do_access && in_range && wen_q && (wmask_q != 4'd0)) begin
                pmem_write(word_addr, wdata_q, {4'b0, wmask_q});
            end
        end
    end

    assign req_ready = (state_q == StIdle) && !reset;
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with LATENCY 1, 4 and 3 share one memory.
module tb_mem_responder;
    logic        clk;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_wen   [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_wmask [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .LATENCY(g == 0 ? 1 : (g == 1 ? 4 : 3))
        ) u_dut (
            .clk      (clk),
            .reset    (rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_wen  (req_wen[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_wmask(req_wmask[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one transaction with rsp_ready high; returns response and accept-to-valid cycles.
    task automatic txn(input int d, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       output logic [31:0] rdata, output logic err, output int cyc);
        req_valid[d] = 1'b1;
        req_wen[d]   = wen;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wmask[d] = wmask;
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        cyc = 0;
        while (!rsp_valid[d] && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        req_wen[d]   = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        for (int i = 0; i < 3; i++) begin
            checks++; if (req_ready[i] !== 1'b0) begin errors++;
                $display("FAIL reset_req_ready[%0d] got=%b exp=0", i, req_ready[i]); end
            checks++; if (rsp_valid[i] !== 1'b0) begin errors++;
                $display("FAIL reset_rsp_valid[%0d] got=%b exp=0", i, rsp_valid[i]); end
            checks++; if (rsp_rdata[i] !== 32'h0) begin errors++;
                $display("FAIL reset_rdata[%0d] got=%h exp=0", i, rsp_rdata[i]); end
            checks++; if (rsp_err[i] !== 1'b0) begin errors++;
                $display("FAIL reset_err[%0d] got=%b exp=0", i, rsp_err[i]); end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (req_ready[i] !== 1'b1) begin errors++;
                $display("FAIL post_reset_ready[%0d] got=%b exp=1", i, req_ready[i]); end
        end
    endtask

    task automatic test_basic_read();
        logic [31:0] rd; logic er; int cyc; int unsigned r0;
        pmem_pkg::pmem_preload(32'h8000_0000, 32'h0000_0297);
        r0 = pmem_pkg::n_reads;
        txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, cyc);
        checks++; if (cyc !== 1) begin errors++;
            $display("FAIL basic_latency got=%0d exp=1", cyc); end
        checks++; if (rd !== 32'h0000_0297) begin errors++;
            $display("FAIL basic_rdata got=%h exp=00000297", rd); end
        checks++; if (er !== 1'b0) begin errors++;
            $display("FAIL basic_err got=%b exp=0", er); end
        checks++; if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin errors++;
            $display("FAIL basic_after_take valid=%b ready=%b exp 0/1", rsp_valid[0], req_ready[0]);
        end
        checks++; if (pmem_pkg::n_reads - r0 !== 1) begin errors++;
            $display("FAIL basic_read_calls got=%0d exp=1", pmem_pkg::n_reads - r0); end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd; logic er; int cyc; int unsigned w0;
        pmem_pkg::pmem_preload(32'h8000_0004, 32'h1122_3344);
        w0 = pmem_pkg::n_writes;
        txn(0, 1'b1, 32'h8000_0004, 32'hAABB_CCDD, 4'b0010, rd, er, cyc);
        checks++; if (pmem_pkg::n_writes - w0 !== 1) begin errors++;
            $display("FAIL bytewr_calls got=%0d exp=1", pmem_pkg::n_writes - w0); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++;
            $display("FAIL bytewr_rsp rdata=%h err=%b exp 0/0", rd, er); end
        txn(0, 1'b0, 32'h8000_0006, 32'h0, 4'h0, rd, er, cyc);
        checks++; if (rd !== 32'h1122_CC44) begin errors++;
            $display("FAIL bytewr_readback got=%h exp=1122cc44", rd); end
        checks++; if (er !== 1'b0) begin errors++;
            $display("FAIL bytewr_read_err got=%b exp=0", er); end
    endtask

    task automatic test_latency_backpressure();
        int cyc; logic rr_bad;
        pmem_pkg::pmem_preload(32'h8000_0010, 32'hDEAD_BEEF);
        req_valid[1] = 1'b1; req_wen[1] = 1'b0; req_addr[1] = 32'h8000_0010;
        rsp_ready[1] = 1'b0;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        cyc = 0; rr_bad = 1'b0;
        while (!rsp_valid[1] && cyc < 50) begin
            if (req_ready[1]) rr_bad = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc !== 4) begin errors++;
            $display("FAIL lat4_latency got=%0d exp=4", cyc); end
        checks++; if (rsp_rdata[1] !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL lat4_rdata got=%h exp=deadbeef", rsp_rdata[1]); end
        for (int i = 0; i < 3; i++) begin
            if (req_ready[1]) rr_bad = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hDEAD_BEEF) begin errors++;
                $display("FAIL lat4_hold[%0d] valid=%b rdata=%h exp 1/deadbeef", i, rsp_valid[1],
                         rsp_rdata[1]);
            end
        end
        if (req_ready[1]) rr_bad = 1'b1;
        checks++; if (rr_bad !== 1'b0) begin errors++;
            $display("FAIL lat4_req_ready_busy got=1 exp=0"); end
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[1] = 1'b0;
        checks++; if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin errors++;
            $display("FAIL lat4_release valid=%b ready=%b exp 0/1", rsp_valid[1], req_ready[1]);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int cyc; int unsigned r0, w0;
        r0 = pmem_pkg::n_reads; w0 = pmem_pkg::n_writes;
        txn(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, rd, er, cyc);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++;
            $display("FAIL oor_read err=%b rdata=%h exp 1/0", er, rd); end
        txn(0, 1'b1, 32'h8800_0000, 32'h1234_5678, 4'hF, rd, er, cyc);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++;
            $display("FAIL oor_write err=%b rdata=%h exp 1/0", er, rd); end
        checks++;
        if (pmem_pkg::n_reads !== r0 || pmem_pkg::n_writes !== w0) begin errors++;
            $display("FAIL oor_calls reads=%0d writes=%0d exp 0/0", pmem_pkg::n_reads - r0,
                     pmem_pkg::n_writes - w0);
        end
        pmem_pkg::pmem_preload(32'h87FF_FFFC, 32'h0000_5A5A);
        txn(0, 1'b0, 32'h87FF_FFFF, 32'h0, 4'h0, rd, er, cyc);
        checks++; if (er !== 1'b0 || rd !== 32'h0000_5A5A) begin errors++;
            $display("FAIL top_of_range err=%b rdata=%h exp 0/00005a5a", er, rd); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd; logic er; int cyc; int unsigned w0;
        pmem_pkg::pmem_preload(32'h8000_0020, 32'h5566_7788);
        txn(2, 1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, cyc);
        checks++; if (cyc !== 3 || rd !== 32'h5566_7788) begin errors++;
            $display("FAIL lat3_read cyc=%0d rdata=%h exp 3/55667788", cyc, rd); end
        w0 = pmem_pkg::n_writes;
        req_valid[2] = 1'b1; req_wen[2] = 1'b1; req_addr[2] = 32'h8000_0020;
        req_wdata[2] = 32'h1234_5678; req_wmask[2] = 4'hF;
        @(posedge clk); #1;
        req_valid[2] = 1'b0; req_wen[2] = 1'b0;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        #1;
        checks++;
        if (req_ready[2] !== 1'b0 || rsp_valid[2] !== 1'b0 || rsp_rdata[2] !== 32'h0 ||
            rsp_err[2] !== 1'b0) begin errors++;
            $display("FAIL midrst_outputs ready=%b valid=%b rdata=%h err=%b exp 0/0/0/0",
                     req_ready[2], rsp_valid[2], rsp_rdata[2], rsp_err[2]);
        end
        rst[2] = 1'b0;
        #1;
        checks++; if (req_ready[2] !== 1'b1) begin errors++;
            $display("FAIL midrst_ready got=%b exp=1", req_ready[2]); end
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (pmem_pkg::n_writes !== w0 || rsp_valid[2] !== 1'b0) begin errors++;
            $display("FAIL midrst_no_write writes=%0d valid=%b exp 0/0",
                     pmem_pkg::n_writes - w0, rsp_valid[2]);
        end
        txn(2, 1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, cyc);
        checks++; if (rd !== 32'h5566_7788) begin errors++;
            $display("FAIL midrst_old_data got=%h exp=55667788", rd); end
    endtask

    task automatic test_zero_mask_ignored();
        logic [31:0] rd; logic er; int cyc; int unsigned w0;
        pmem_pkg::pmem_preload(32'h8000_0030, 32'hCAFE_F00D);
        pmem_pkg::pmem_preload(32'h8000_0034, 32'h0BAD_BEEF);
        w0 = pmem_pkg::n_writes;
        txn(0, 1'b1, 32'h8000_0030, 32'hFFFF_FFFF, 4'h0, rd, er, cyc);
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++;
            $display("FAIL zmask_rsp err=%b rdata=%h exp 0/0", er, rd); end
        checks++;
        if (pmem_pkg::n_writes !== w0 || pmem_pkg::pmem_peek(32'h8000_0030) !== 32'hCAFE_F00D)
        begin errors++;
            $display("FAIL zmask_no_write writes=%0d mem=%h exp 0/cafef00d",
                     pmem_pkg::n_writes - w0, pmem_pkg::pmem_peek(32'h8000_0030));
        end
        req_valid[1] = 1'b1; req_wen[1] = 1'b0; req_addr[1] = 32'h8000_0034;
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        cyc = 0;
        while (!rsp_valid[1] && cyc < 50) begin
            req_addr[1] = 32'h8000_0030; req_wen[1] = 1'b1;
            req_wdata[1] = 32'h0101_0101 * cyc; req_wmask[1] = 4'hF;
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (rsp_rdata[1] !== 32'h0BAD_BEEF || rsp_err[1] !== 1'b0) begin errors++;
            $display("FAIL ignored_inputs rdata=%h err=%b exp 0badbeef/0", rsp_rdata[1],
                     rsp_err[1]);
        end
        @(posedge clk); #1;
        rsp_ready[1] = 1'b0; req_wen[1] = 1'b0;
        checks++; if (pmem_pkg::n_writes !== w0) begin errors++;
            $display("FAIL ignored_no_write writes=%0d exp=0", pmem_pkg::n_writes - w0); end
    endtask

    task automatic test_back_to_back();
        int acc; int unsigned r0;
        r0 = pmem_pkg::n_reads;
        acc = 0;
        req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 32'h8000_0000;
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (req_ready[0]) acc++;
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        checks++; if (acc !== 3) begin errors++;
            $display("FAIL b2b_accepts got=%0d exp=3", acc); end
        checks++; if (pmem_pkg::n_reads - r0 !== 3) begin errors++;
            $display("FAIL b2b_reads got=%0d exp=3", pmem_pkg::n_reads - r0); end
        checks++; if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin errors++;
            $display("FAIL b2b_end ready=%b valid=%b exp 1/0", req_ready[0], rsp_valid[0]); end
        rsp_ready[0] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_wen[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0; req_wmask[i] = '0; rsp_ready[i] = 1'b0;
        end
        test_reset();
        test_basic_read();
        test_byte_write();
        test_latency_backpressure();
        test_out_of_range();
        test_reset_mid_write();
        test_zero_mask_ignored();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's instruction-fetch and load/store request handshakes. It accepts one read or write request, waits a fixed access latency, performs the access through the `pmem_read` / `pmem_write` DPI-C functions, and holds the response until the requester takes it. It sits between the fetch/load-store front ends and simulated physical memory. This lets fetch and load/store stall on a real multi-cycle memory instead of reading combinationally.

## Interface
- `ADDR_W`, 32, request address width
- `DATA_W`, 32, data width; fixed at 32 to match the DPI `int` type
- `LATENCY`, 1, cycles from request acceptance to response valid; legal range 1..15
- `MEM_BASE`, 32'h80000000, first valid physical address
- `MEM_SIZE`, 32'h08000000, size of the valid region in bytes
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder can accept a request
- `req_wen`  in  1  1 = write, 0 = read
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  write data
- `req_wmask`  in  4  byte enables for writes; bit i enables byte i
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  requester takes the response
- `rsp_rdata`  out  32  read data; 0 for writes and for errors
- `rsp_err`  out  1  address fell outside `[MEM_BASE, MEM_BASE+MEM_SIZE)`

## Operation
- **States**
  - IDLE, WAIT and RESP.
  - `req_ready` = (state == IDLE).
  - `rsp_valid` = (state == RESP).
- **IDLE**
  - On `req_valid & req_ready`, latch `req_wen`, `req_addr`, `req_wdata` and `req_wmask`.
  - Load the counter with `LATENCY-1` and go to WAIT.
  - After acceptance, changes on the `req_*` inputs are ignored until the next acceptance.
- **WAIT**
  - If counter ≠ 0, decrement it.
  - If counter == 0, perform the access and go to RESP.
- **Access rules**
  - Range check uses 33-bit arithmetic so `MEM_BASE+MEM_SIZE` cannot wrap.
  - Out of range: no DPI call. `rsp_err`=1 and `rsp_rdata`=0.
  - Read: `rsp_rdata` = `pmem_read({addr[31:2],2'b00})`.
  - Write with `wmask` ≠ 0: call `pmem_write({addr[31:2],2'b00}, wdata, {4'b0,wmask})` exactly once. `rsp_rdata`=0.
  - Write with `wmask` == 0: no DPI call. Normal response with `rsp_err`=0.
- **RESP**
  - `rsp_rdata` and `rsp_err` stay stable while `rsp_valid`=1.
  - On `rsp_ready`, go to IDLE.
  - `rsp_ready` while not in RESP is ignored.
- **Exclusions**
  - Only one transaction is outstanding at a time; there is no pipelining.
  - Misalignment is not an error. Low address bits are dropped for the access.
  - The requester selects the byte or halfword from `rsp_rdata` itself.

## Timing
- **Reset** (asynchronous, takes effect immediately)
  - State IDLE, counter 0.
  - `req_ready`=1 once reset deasserts; it is 0 while `reset` is high.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - No DPI call is made while `reset` is high.
- **Reset mid-transaction**
  - Reset in WAIT before the access edge: the pending write is never performed.
  - Reset in RESP: the response is discarded.
- **Latency**
  - Request accepted at edge k gives `rsp_valid`=1 after edge k+`LATENCY`.
  - The DPI call happens at edge k+`LATENCY`.
- **Response handshake**
  - Response taken at edge j gives `req_ready`=1 after edge j.
  - A new request cannot be accepted at edge j itself.
  - Minimum transaction period is `LATENCY`+2 cycles when `rsp_ready` is tied high.
- **Ordering**: the write side effect is visible to any read accepted after that write's response handshake.

## Test plan
- **Basic read**
  - Stimulus: `LATENCY`=1. Preload word 0x80000000 = 0x00000297. Read 0x80000000 accepted at edge 1, `rsp_ready`=1.
  - Required: `rsp_valid`=1 only in the cycle after edge 2, `rsp_rdata`=0x00000297, `rsp_err`=0, `req_ready`=1 after edge 3.
- **Byte write then read**
  - Stimulus: write 0x80000004, wdata 0xAABBCCDD, wmask 4'b0010, over word 0x11223344. Then read 0x80000006.
  - Required: exactly one `pmem_write`. Read returns 0x1122CC44, `rsp_err`=0.
- **Latency and backpressure**
  - Stimulus: `LATENCY`=4. Read accepted at edge 10. Hold `rsp_ready`=0 for 3 cycles after `rsp_valid` rises.
  - Required: `rsp_valid` rises after edge 14, `rsp_rdata` is stable for all 4 valid cycles, `req_ready`=0 throughout.
- **Out-of-range access**
  - Stimulus: read 0x00001000, and write to 0x88000000 with `MEM_SIZE` default.
  - Required: `rsp_err`=1, `rsp_rdata`=0, no DPI call for either.
- **Asynchronous reset mid-write**
  - Stimulus: `LATENCY`=3. Write accepted at edge 5. Pulse `reset` between edges 6 and 7.
  - Required: outputs go to reset values immediately, with `req_ready`=1 once reset deasserts. No `pmem_write` occurs; a later read shows the old data.
- **Zero-mask write and ignored inputs**
  - Stimulus: write with wmask 0. Then change `req_addr` during WAIT of a following read.
  - Required: zero-mask write gives a normal response and no DPI call. The read returns data for the address latched at acceptance.
